// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_responder
//  Purpose  : Memory-mapped I/O responder for CPU LDS/STS accesses at
//             $80-$83. Holds the LED and display registers, synchronises the
//             switch pins and scans a 4-digit active-low 7-segment display.
//             Optional macro IO_SW_EDGE_EN adds the sticky rising-edge
//             register SW_EDGE at $84.
//  Revision : 1.0 - initial release
// ============================================================================
module io_port_responder #(
    parameter int SCAN_DIV    = 16,  // refresh counter width, >= 3
    parameter int SYNC_STAGES = 2    // switch synchroniser depth, >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       re,
    output logic [7:0] rdata,
    output logic       sel,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [7:0] c_ADDR_LED  = 8'h80;
    localparam logic [7:0] c_ADDR_SW   = 8'h81;
    localparam logic [7:0] c_ADDR_DLO  = 8'h82;
    localparam logic [7:0] c_ADDR_DHI  = 8'h83;
`ifdef IO_SW_EDGE_EN
    localparam logic [7:0] c_ADDR_EDGE = 8'h84;
`endif
    localparam logic [SCAN_DIV-1:0] c_SCAN_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

    logic [7:0]                   r_led;
    logic [7:0]                   r_disp_lo;
    logic [7:0]                   r_disp_hi;
    logic [SYNC_STAGES-1:0][7:0]  r_sync;
    logic [SCAN_DIV-1:0]          r_scan_cnt;
    logic [3:0]                   r_an;
    logic [6:0]                   r_seg;

    logic                         w_sel;
    logic [7:0]                   w_sw_sync;
    logic [1:0]                   w_idx;
    logic [3:0]                   w_nibble;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_hex7(input logic [3:0] i_n);
        case (i_n)
            4'h0:    f_hex7 = 7'b1000000;
            4'h1:    f_hex7 = 7'b1111001;
            4'h2:    f_hex7 = 7'b0100100;
            4'h3:    f_hex7 = 7'b0110000;
            4'h4:    f_hex7 = 7'b0011001;
            4'h5:    f_hex7 = 7'b0010010;
            4'h6:    f_hex7 = 7'b0000010;
            4'h7:    f_hex7 = 7'b1111000;
            4'h8:    f_hex7 = 7'b0000000;
            4'h9:    f_hex7 = 7'b0010000;
            4'hA:    f_hex7 = 7'b0001000;
            4'hB:    f_hex7 = 7'b0000011;
            4'hC:    f_hex7 = 7'b1000110;
            4'hD:    f_hex7 = 7'b0100001;
            4'hE:    f_hex7 = 7'b0000110;
            default: f_hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_sw_sync = r_sync[SYNC_STAGES-1];
    assign w_idx     = r_scan_cnt[SCAN_DIV-1 -: 2];

`ifdef IO_SW_EDGE_EN
    logic [7:0] r_sw_prev;
    logic [7:0] r_edge;
    logic [7:0] w_rise;
    logic       w_edge_clr;

    assign w_sel      = (addr[7:2] == 6'b100000) || (addr == c_ADDR_EDGE);
    assign w_rise     = w_sw_sync & ~r_sw_prev;
    assign w_edge_clr = re && (addr == c_ADDR_EDGE);

    // Sticky rise flags; a rise seen on the clearing edge wins over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_prev <= 8'h00;
            r_edge    <= 8'h00;
        end else begin
            r_sw_prev <= w_sw_sync;
            r_edge    <= (w_edge_clr ? 8'h00 : r_edge) | w_rise;
        end
    end
`else
    assign w_sel = (addr[7:2] == 6'b100000);
`endif

    assign sel = w_sel;

    // Zero-latency read mux of registered state; reads have no side effects here
    always_comb begin
        rdata = 8'h00;
        if (re && w_sel) begin
            case (addr)
                c_ADDR_LED:  rdata = r_led;
                c_ADDR_SW:   rdata = w_sw_sync;
                c_ADDR_DLO:  rdata = r_disp_lo;
                c_ADDR_DHI:  rdata = r_disp_hi;
`ifdef IO_SW_EDGE_EN
                c_ADDR_EDGE: rdata = r_edge;
`endif
                default:     rdata = 8'h00;
            endcase
        end
    end

    // Writable registers; SW and SW_EDGE fall through to the default and ignore writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led     <= 8'h00;
            r_disp_lo <= 8'h00;
            r_disp_hi <= 8'h00;
        end else if (we && w_sel) begin
            case (addr)
                c_ADDR_LED: r_led     <= wdata;
                c_ADDR_DLO: r_disp_lo <= wdata;
                c_ADDR_DHI: r_disp_hi <= wdata;
                default:    ;
            endcase
        end
    end

    // Switch synchroniser chain; the last stage is the architecturally visible value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Pick the nibble for the digit currently being scanned
    always_comb begin
        case (w_idx)
            2'd0:    w_nibble = r_disp_lo[3:0];
            2'd1:    w_nibble = r_disp_lo[7:4];
            2'd2:    w_nibble = r_disp_hi[3:0];
            default: w_nibble = r_disp_hi[7:4];
        endcase
    end

    // Free-running scan counter; an/seg registered so digit changes are glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_an       <= 4'b1110;
            r_seg      <= 7'b1000000;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_ONE;
            r_an       <= ~(4'b0001 << w_idx);
            r_seg      <= f_hex7(w_nibble);
        end
    end

    assign led = r_led;
    assign an  = r_an;
    assign seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port_responder
//  Purpose  : Self-checking bench for io_port_responder. Directed steps plus
//             a randomized bus phase, checked against a behavioural model
//             (register array, sampled-switch history, cycle-count display).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_responder;

    localparam int SCAN_DIV    = 4;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr, wdata, sw;
    logic       we, re;
    logic [7:0] rdata, led;
    logic       sel;
    logic [6:0] seg;
    logic [3:0] an;

    int n_tests = 0;
    int n_fail  = 0;

    io_port_responder #(.SCAN_DIV(SCAN_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .sel(sel), .sw(sw), .led(led), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [7:0] m_reg [4];      // index = addr - $80 ($81 slot unused)
    logic [7:0] hist [$];       // sw value sampled at each edge since reset
    logic [7:0] m_flags;
    int         m_n;            // edges since reset release
    logic [3:0] m_an;
    logic [6:0] m_seg;

    // Synchronised switch value, 'back' edges ago (0 = current)
    function automatic logic [7:0] m_sync(input int back);
        int k;
        k = hist.size() - SYNC_STAGES - back;
        return (k >= 0) ? hist[k] : 8'h00;
    endfunction

    function automatic logic m_sel(input logic [7:0] a);
        logic s;
        s = (a >= 8'h80 && a <= 8'h83);
`ifdef IO_SW_EDGE_EN
        s = s || (a == 8'h84);
`endif
        return s;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h80:   return m_reg[0];
            8'h81:   return m_sync(0);
            8'h82:   return m_reg[2];
            8'h83:   return m_reg[3];
`ifdef IO_SW_EDGE_EN
            8'h84:   return m_flags;
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        hist.delete();
        m_flags = 8'h00;
        m_n     = 0;
        m_an    = 4'b1110;
        m_seg   = 7'b1000000;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, predicting every state change from current inputs
    task automatic step();
        int         idx;
        logic [15:0] disp;
        logic [3:0] nan;
        logic [7:0] nflags;
        logic [7:0] nreg [4];
        idx  = (m_n % (1 << SCAN_DIV)) / (1 << (SCAN_DIV - 2));
        disp = {m_reg[3], m_reg[2]};
        nan  = 4'b1111;
        nan[idx] = 1'b0;
        nflags = m_flags;
`ifdef IO_SW_EDGE_EN
        if (re && addr == 8'h84) nflags = 8'h00;
        nflags = nflags | (m_sync(0) & ~m_sync(1));
`endif
        nreg = m_reg;
        if (we && m_sel(addr) && (addr == 8'h80 || addr == 8'h82 || addr == 8'h83))
            nreg[addr - 8'h80] = wdata;
        @(posedge clk);
        m_an    = nan;
        m_seg   = HEX[disp[idx*4 +: 4]];
        m_flags = nflags;
        m_reg   = nreg;
        hist.push_back(sw);
        if (hist.size() > SYNC_STAGES + 2) void'(hist.pop_front());
        m_n++;
        #1;
    endtask

    // One bus cycle with full model checking
    task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic w, input logic r);
        addr = a; wdata = d; we = w; re = r;
        #1;
        chk("sel", {7'b0, sel}, {7'b0, m_sel(a)});
        chk("rdata", rdata, (r && m_sel(a)) ? m_read(a) : 8'h00);
        step();
        chk("led", led, m_reg[0]);
        chk("an", {4'b0, an}, {4'b0, m_an});
        chk("seg", {1'b0, seg}, {1'b0, m_seg});
    endtask

    // Combinational read probe against a fixed expected value
    task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
        addr = a; re = 1'b1; we = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    logic [3:0] SCAN_AN  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] SCAN_SEG [4] = '{7'b0001110, 7'b0000000, 7'b0100100, 7'b1111001};

    initial begin
        int waited;
        reset = 1'b1; addr = 8'h00; wdata = 8'h00; we = 1'b0; re = 1'b0; sw = 8'h00;
        model_reset();
        #3;
        chk("rst_led", led, 8'h00);
        chk("rst_an", {4'b0, an}, 8'h0E);
        chk("rst_seg", {1'b0, seg}, 8'h40);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Idle after reset
        bus(8'h00, 8'h00, 1'b0, 1'b1);
        bus(8'h00, 8'h00, 1'b0, 1'b0);
        chk("idle_sel", {7'b0, sel}, 8'h00);

        // LED write / read back
        bus(8'h80, 8'hA5, 1'b1, 1'b0);
        chk("led_a5", led, 8'hA5);
        peek(8'h80, 8'hA5, "rd_led");
        bus(8'h80, 8'h00, 1'b0, 1'b1);
        // Write attempt to SW register, read it in the same cycle
        addr = 8'h81; wdata = 8'hFF; we = 1'b1; re = 1'b1; #1;
        chk("rd_sw", rdata, 8'h00);
        bus(8'h81, 8'hFF, 1'b1, 1'b1);
        chk("sw_wr_ign", led, 8'hA5);

        // Switch synchroniser latency
        sw = 8'h3C;
        peek(8'h81, 8'h00, "sync0");
        bus(8'h81, 8'h00, 1'b0, 1'b1);
        peek(8'h81, 8'h00, "sync1");
        bus(8'h81, 8'h00, 1'b0, 1'b1);
        peek(8'h81, 8'h3C, "sync2");

        // Simultaneous read and write of the same register
        bus(8'h82, 8'h11, 1'b1, 1'b0);
        addr = 8'h82; wdata = 8'h77; we = 1'b1; re = 1'b1; #1;
        chk("rw_old", rdata, 8'h11);
        bus(8'h82, 8'h77, 1'b1, 1'b1);
        peek(8'h82, 8'h77, "rw_new");

        // Display scan with DISP_HI=$12, DISP_LO=$8F
        bus(8'h83, 8'h12, 1'b1, 1'b0);
        bus(8'h82, 8'h8F, 1'b1, 1'b0);
        waited = 0;
        while (an === 4'b1110 && waited < 40) begin bus(8'h00, 8'h00, 1'b0, 1'b0); waited++; end
        while (an !== 4'b1110 && waited < 40) begin bus(8'h00, 8'h00, 1'b0, 1'b0); waited++; end
        chk("scan_sync", {4'b0, an}, 8'h0E);
        for (int dgt = 0; dgt < 5; dgt++) begin
            chk("scan_an", {4'b0, an}, {4'b0, SCAN_AN[dgt % 4]});
            chk("scan_seg", {1'b0, seg}, {1'b0, SCAN_SEG[dgt % 4]});
            repeat (4) bus(8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Unmapped addresses
        addr = 8'h7F; we = 1'b1; re = 1'b1; wdata = 8'h5A; #1;
        chk("sel_7f", {7'b0, sel}, 8'h00);
        chk("rd_7f", rdata, 8'h00);
        bus(8'h7F, 8'h5A, 1'b1, 1'b1);
`ifndef IO_SW_EDGE_EN
        addr = 8'h84; #1;
        chk("sel_84", {7'b0, sel}, 8'h00);
        chk("rd_84", rdata, 8'h00);
`endif
        bus(8'h84, 8'h5A, 1'b1, 1'b1);
        peek(8'h80, 8'hA5, "unmap_led");

        // Randomized bus traffic
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            int pick;
            pick = $urandom_range(0, 7);
            if (pick <= 4)      a = 8'(8'h80 + pick);
            else if (pick == 5) a = 8'h7F;
            else if (pick == 6) a = 8'h00;
            else                a = 8'($urandom);
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            bus(a, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef IO_SW_EDGE_EN
        // Sticky edge flags
        sw = 8'h00;
        repeat (4) bus(8'h00, 8'h00, 1'b0, 1'b0);
        bus(8'h84, 8'h00, 1'b0, 1'b1);
        sw = 8'h05;
        repeat (4) bus(8'h00, 8'h00, 1'b0, 1'b0);
        peek(8'h84, 8'h05, "edge_05");
        bus(8'h84, 8'h00, 1'b0, 1'b1);
        sw = 8'h85;
        peek(8'h84, 8'h00, "edge_clr");
        bus(8'h84, 8'h00, 1'b0, 1'b1);
        bus(8'h00, 8'h00, 1'b0, 1'b0);
        peek(8'h84, 8'h00, "edge_race");
        bus(8'h84, 8'h00, 1'b0, 1'b1);
        peek(8'h84, 8'h80, "edge_keep");
        bus(8'h84, 8'h00, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-scan
        bus(8'h80, 8'hA5, 1'b1, 1'b0);
        bus(8'h00, 8'h00, 1'b0, 1'b0);
        bus(8'h00, 8'h00, 1'b0, 1'b0);
        we = 1'b0; re = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_an", {4'b0, an}, 8'h0E);
        chk("arst_seg", {1'b0, seg}, 8'h40);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (6) bus(8'h80, 8'h00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
